// File: rtl/csr_sequencer.sv
// Sequences one SYSTEM/CSR instruction (or external exception) into CSR-file strobes.
// CSR op: 2-3 cycles, traps: 3-4 cycles, MRET: 3 cycles; start/exc_req are ignored while busy.
module csr_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instr,
    input  logic [31:0]     pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            exc_req,
    input  logic [4:0]      exc_cause,
    output logic [11:0]     csr_addr,
    output logic            csr_read,
    output logic            csr_write,
    output logic [1:0]      csr_write_type,
    output logic            csr_trap,
    output logic [4:0]      csr_trap_cause,
    output logic            csr_ret,
    input  logic            csr_invalid,
    input  logic [XLEN-1:0] bus_in,
    output logic [XLEN-1:0] bus_out,
    output logic            bus_oe,
    output logic            busy,
    output logic            done,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            pc_load,
    output logic [31:0]     pc_next
);
    typedef enum logic [2:0] {
        IDLE, READ, WRITE, TRAP, TVEC, RETRD, RET, DONE
    } state_t;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [11:0] ADDR_MTVEC = 12'h305;
    localparam logic [11:0] ADDR_MEPC  = 12'h341;

    state_t          state_q, state_d;
    logic [11:0]     csr_q, csr_d;
    logic [4:0]      rs1f_q, rs1f_d;
    logic [1:0]      wtype_q, wtype_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     pc_q, pc_d;
    logic [XLEN-1:0] src_q, src_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [31:0]     pc_next_q, pc_next_d;
    logic [4:0]      cause_q, cause_d;
    logic            csr_op_q, csr_op_d;

    logic [2:0] funct3;
    logic       is_system;
    logic       write_needed;

    assign funct3       = instr[14:12];
    assign is_system    = (instr[6:0] == OPC_SYSTEM);
    // Set/clear with a zero rs1 field is a pure read and must not touch the CSR.
    assign write_needed = (wtype_q == 2'b01) || (rs1f_q != 5'd0);

    always_comb begin
        state_d   = state_q;
        csr_d     = csr_q;
        rs1f_d    = rs1f_q;
        wtype_d   = wtype_q;
        rd_d      = rd_q;
        pc_d      = pc_q;
        src_d     = src_q;
        old_d     = old_q;
        pc_next_d = pc_next_q;
        cause_d   = cause_q;
        csr_op_d  = csr_op_q;
        case (state_q)
            IDLE: begin
                if (exc_req) begin
                    state_d  = TRAP;
                    cause_d  = exc_cause;
                    pc_d     = pc;
                    rd_d     = 5'd0;
                    csr_op_d = 1'b0;
                end else if (start) begin
                    csr_d    = instr[31:20];
                    rs1f_d   = instr[19:15];
                    wtype_d  = instr[13:12];
                    rd_d     = instr[11:7];
                    pc_d     = pc;
                    src_d    = funct3[2] ? {{(XLEN-5){1'b0}}, instr[19:15]} : rs1_val;
                    csr_op_d = 1'b0;
                    if (is_system && funct3 != 3'b000 && funct3 != 3'b100) begin
                        state_d  = READ;
                        csr_op_d = 1'b1;
                    end else if (is_system && funct3 == 3'b000 && instr[31:20] == 12'h000) begin
                        state_d = TRAP;
                        cause_d = 5'd11;
                    end else if (is_system && funct3 == 3'b000 && instr[31:20] == 12'h001) begin
                        state_d = TRAP;
                        cause_d = 5'd3;
                    end else if (is_system && funct3 == 3'b000 && instr[31:20] == 12'h302) begin
                        state_d = RETRD;
                    end else begin
                        state_d = TRAP;
                        cause_d = 5'd2;
                    end
                end
            end
            READ: begin
                if (csr_invalid) begin
                    state_d  = TRAP;
                    cause_d  = 5'd2;
                    csr_op_d = 1'b0;
                end else begin
                    old_d     = bus_in;
                    pc_next_d = pc_q + 32'd4;
                    if (write_needed && csr_q[11:10] == 2'b11) begin
                        state_d  = TRAP;
                        cause_d  = 5'd2;
                        csr_op_d = 1'b0;
                    end else if (write_needed) begin
                        state_d = WRITE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: state_d = DONE;
            TRAP:  state_d = TVEC;
            TVEC: begin
                pc_next_d = 32'(bus_in);
                state_d   = DONE;
            end
            RETRD: begin
                pc_next_d = 32'(bus_in);
                state_d   = RET;
            end
            RET:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            csr_q     <= '0;
            rs1f_q    <= '0;
            wtype_q   <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            src_q     <= '0;
            old_q     <= '0;
            pc_next_q <= '0;
            cause_q   <= '0;
            csr_op_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            csr_q     <= csr_d;
            rs1f_q    <= rs1f_d;
            wtype_q   <= wtype_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            src_q     <= src_d;
            old_q     <= old_d;
            pc_next_q <= pc_next_d;
            cause_q   <= cause_d;
            csr_op_q  <= csr_op_d;
        end
    end

    always_comb begin
        csr_addr = 12'h000;
        case (state_q)
            READ, WRITE: csr_addr = csr_q;
            TVEC:        csr_addr = ADDR_MTVEC;
            RETRD:       csr_addr = ADDR_MEPC;
            default:     csr_addr = 12'h000;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign csr_read       = (state_q == READ) || (state_q == TVEC) || (state_q == RETRD);
    assign csr_write      = (state_q == WRITE);
    assign csr_write_type = (state_q == WRITE) ? wtype_q : 2'b00;
    assign csr_trap       = (state_q == TRAP);
    assign csr_trap_cause = (state_q == TRAP) ? cause_q : 5'd0;
    assign csr_ret        = (state_q == RET);
    assign bus_oe         = (state_q == WRITE) || (state_q == TRAP);
    // The trap cycle drives the faulting PC so the CSR file can capture it into mepc.
    assign bus_out        = (state_q == WRITE) ? src_q :
                            (state_q == TRAP)  ? XLEN'(pc_q) : '0;
    assign done           = (state_q == DONE);
    assign pc_load        = (state_q == DONE);
    assign pc_next        = (state_q == DONE) ? pc_next_q : 32'd0;
    assign rd_addr        = (state_q == DONE) ? rd_q : 5'd0;
    assign rd_we          = (state_q == DONE) && csr_op_q && (rd_q != 5'd0);
    assign rd_data        = ((state_q == DONE) && csr_op_q) ? old_q : '0;
endmodule

// File: tb/tb_csr_sequencer.sv
// Directed scoreboard bench for csr_sequencer: expected strobe events are queued at issue time.
module tb_csr_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic [11:0] csr_addr;
    logic        csr_read;
    logic        csr_write;
    logic [1:0]  csr_write_type;
    logic        csr_trap;
    logic [4:0]  csr_trap_cause;
    logic        csr_ret;
    logic        csr_invalid;
    logic [31:0] bus_in;
    logic [31:0] bus_out;
    logic        bus_oe;
    logic        busy;
    logic        done;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        pc_load;
    logic [31:0] pc_next;

    csr_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .pc(pc), .rs1_val(rs1_val),
        .exc_req(exc_req), .exc_cause(exc_cause), .csr_addr(csr_addr), .csr_read(csr_read),
        .csr_write(csr_write), .csr_write_type(csr_write_type), .csr_trap(csr_trap),
        .csr_trap_cause(csr_trap_cause), .csr_ret(csr_ret), .csr_invalid(csr_invalid),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .busy(busy), .done(done),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .pc_load(pc_load), .pc_next(pc_next)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] K_RD = 3'd1, K_WR = 3'd2, K_TR = 3'd3, K_RET = 3'd4, K_DN = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [7:0]  off;
        logic [11:0] addr;
        logic [4:0]  aux;
        logic        oe;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        we;
        logic        pl;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  t0 = 0;

    // CSR file model
    logic [31:0] csr_val, mtvec, mepc;
    logic [11:0] bad_addr;
    always_comb begin
        bus_in = csr_val;
        if (csr_addr == 12'h305) bus_in = mtvec;
        else if (csr_addr == 12'h341) bus_in = mepc;
    end
    assign csr_invalid = csr_read && (csr_addr == bad_addr);

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(logic [2:0] k, int off, logic [11:0] a, logic [4:0] x, logic oe,
                               logic [31:0] d0, logic [31:0] d1, logic we, logic pl);
        ev_t e;
        e.kind = k; e.off = 8'(off); e.addr = a; e.aux = x; e.oe = oe;
        e.d0 = d0; e.d1 = d1; e.we = we; e.pl = pl;
        return e;
    endfunction

    // Monitor: every strobe/done cycle is one event matched against the scoreboard
    always @(negedge clk) begin
        int  n;
        ev_t o;
        ev_t e;
        n = $countones({csr_read, csr_write, csr_trap, csr_ret, done});
        if (n > 0) begin
            if (n > 1) begin
                total++; bad++;
                $display("FAIL onehot: %0d strobes active, required 1", n);
            end
            o.kind = done ? K_DN : csr_ret ? K_RET : csr_trap ? K_TR : csr_write ? K_WR : K_RD;
            o.off  = 8'(cyc - t0);
            o.addr = csr_addr;
            o.aux  = csr_write ? {3'b000, csr_write_type} : csr_trap ? csr_trap_cause : rd_addr;
            o.oe   = bus_oe;
            o.d0   = done ? rd_data : bus_out;
            o.d1   = pc_next;
            o.we   = rd_we;
            o.pl   = pc_load;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected event: kind=%0d off=%0d addr=%h, required none", o.kind, o.off, o.addr);
            end else begin
                e = sb.pop_front();
                if (o !== e)  begin
                    bad++;
                    $display("FAIL event: got k=%0d off=%0d a=%h x=%0d oe=%b d0=%h d1=%h we=%b pl=%b, need k=%0d off=%0d a=%h x=%0d oe=%b d0=%h d1=%h we=%b pl=%b",
                             o.kind, o.off, o.addr, o.aux, o.oe, o.d0, o.d1, o.we, o.pl,
                             e.kind, e.off, e.addr, e.aux, e.oe, e.d0, e.d1, e.we, e.pl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_flags"}, 32'({csr_read, csr_write, csr_trap, csr_ret, bus_oe, busy, done, rd_we, pc_load}), 32'd0);
        chk({name, "_addr"}, 32'(csr_addr), 32'd0);
        chk({name, "_bus_out"}, bus_out, 32'd0);
        chk({name, "_pc_next"}, pc_next, 32'd0);
        chk({name, "_rd_data"}, rd_data, 32'd0);
        chk({name, "_fields"}, 32'({rd_addr, csr_write_type, csr_trap_cause}), 32'd0);
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r,
                         input logic e, input logic [4:0] c);
        instr = i; pc = p; rs1_val = r; exc_req = e; exc_cause = c; start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0; exc_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected events missing, need 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] csri(logic [11:0] a, logic [4:0] r1, logic [2:0] f3, logic [4:0] rd);
        return {a, r1, f3, rd, 7'b1110011};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; instr = '0; pc = '0; rs1_val = '0; exc_req = 1'b0; exc_cause = '0;
        csr_val = 32'h0; mtvec = 32'h4; mepc = 32'h1234; bad_addr = 12'hABC;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        // CSRRW 0x340, rs1=DEADBEEF, rd=5
        csr_val = 32'h7;
        sb.push_back(mk(K_RD, 1, 12'h340, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_WR, 2, 12'h340, 1, 1, 32'hDEADBEEF, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 5, 0, 32'h7, 32'h104, 1, 1));
        issue(csri(12'h340, 5'd1, 3'b001, 5'd5), 32'h100, 32'hDEADBEEF, 0, 0);
        drain("csrrw");

        // CSRRS rs1=0: read only
        csr_val = 32'h1800;
        sb.push_back(mk(K_RD, 1, 12'h300, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 2, 0, 3, 0, 32'h1800, 32'h24, 1, 1));
        issue(csri(12'h300, 5'd0, 3'b010, 5'd3), 32'h20, 32'hFFFFFFFF, 0, 0);
        drain("csrrs_nowrite");

        // same with rd=0: no register write
        sb.push_back(mk(K_RD, 1, 12'h300, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 2, 0, 0, 0, 32'h1800, 32'h34, 0, 1));
        issue(csri(12'h300, 5'd0, 3'b010, 5'd0), 32'h30, 32'h0, 0, 0);
        drain("csrrs_rd0");

        // CSRRSI zimm=1F
        sb.push_back(mk(K_RD, 1, 12'h300, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_WR, 2, 12'h300, 2, 1, 32'h1F, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 2, 0, 32'h1800, 32'h44, 1, 1));
        issue(csri(12'h300, 5'd31, 3'b110, 5'd2), 32'h40, 32'h12345678, 0, 0);
        drain("csrrsi");

        // CSRRWI zimm=0 still writes
        sb.push_back(mk(K_RD, 1, 12'h340, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_WR, 2, 12'h340, 1, 1, 32'h0, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 0, 0, 32'h1800, 32'h64, 0, 1));
        issue(csri(12'h340, 5'd0, 3'b101, 5'd0), 32'h60, 32'hAAAA5555, 0, 0);
        drain("csrrwi0");

        // ECALL
        sb.push_back(mk(K_TR, 1, 0, 11, 1, 32'h200, 0, 0, 0));
        sb.push_back(mk(K_RD, 2, 12'h305, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 0, 0, 0, 32'h4, 0, 1));
        issue(32'h00000073, 32'h200, 32'h0, 0, 0);
        drain("ecall");

        // EBREAK
        sb.push_back(mk(K_TR, 1, 0, 3, 1, 32'h300, 0, 0, 0));
        sb.push_back(mk(K_RD, 2, 12'h305, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 0, 0, 0, 32'h4, 0, 1));
        issue(32'h00100073, 32'h300, 32'h0, 0, 0);
        drain("ebreak");

        // non-SYSTEM opcode
        sb.push_back(mk(K_TR, 1, 0, 2, 1, 32'h310, 0, 0, 0));
        sb.push_back(mk(K_RD, 2, 12'h305, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 0, 0, 0, 32'h4, 0, 1));
        issue(32'h00000013, 32'h310, 32'h0, 0, 0);
        drain("illegal_opc");

        // SYSTEM funct3=100
        sb.push_back(mk(K_TR, 1, 0, 2, 1, 32'h320, 0, 0, 0));
        sb.push_back(mk(K_RD, 2, 12'h305, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 0, 0, 0, 32'h4, 0, 1));
        issue(csri(12'h340, 5'd0, 3'b100, 5'd0), 32'h320, 32'h0, 0, 0);
        drain("illegal_f3");

        // CSRRW to an address the CSR file rejects
        bad_addr = 12'h7C0;
        sb.push_back(mk(K_RD, 1, 12'h7C0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_TR, 2, 0, 2, 1, 32'h400, 0, 0, 0));
        sb.push_back(mk(K_RD, 3, 12'h305, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 4, 0, 1, 0, 0, 32'h4, 0, 1));
        issue(csri(12'h7C0, 5'd2, 3'b001, 5'd1), 32'h400, 32'h55, 0, 0);
        drain("csr_invalid");
        bad_addr = 12'hABC;

        // CSRRC with rs1=1 on read-only F14
        sb.push_back(mk(K_RD, 1, 12'hF14, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_TR, 2, 0, 2, 1, 32'h500, 0, 0, 0));
        sb.push_back(mk(K_RD, 3, 12'h305, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 4, 0, 4, 0, 0, 32'h4, 0, 1));
        issue(csri(12'hF14, 5'd1, 3'b011, 5'd4), 32'h500, 32'h1, 0, 0);
        drain("ro_write");

        // CSRRS rs1=0 on read-only F14 is a legal read
        csr_val = 32'h9;
        sb.push_back(mk(K_RD, 1, 12'hF14, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 2, 0, 6, 0, 32'h9, 32'h514, 1, 1));
        issue(csri(12'hF14, 5'd0, 3'b010, 5'd6), 32'h510, 32'h0, 0, 0);
        drain("ro_read");

        // MRET
        sb.push_back(mk(K_RD, 1, 12'h341, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_RET, 2, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 0, 0, 0, 32'h1234, 0, 1));
        issue(32'h30200073, 32'h600, 32'h0, 0, 0);
        drain("mret");

        // exception request beats simultaneous start
        sb.push_back(mk(K_TR, 1, 0, 7, 1, 32'h700, 0, 0, 0));
        sb.push_back(mk(K_RD, 2, 12'h305, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 0, 0, 0, 32'h4, 0, 1));
        issue(32'h30200073, 32'h700, 32'h0, 1, 5'd7);
        drain("exc_prio");

        // start/exc_req while busy are dropped
        csr_val = 32'h7;
        sb.push_back(mk(K_RD, 1, 12'h340, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_WR, 2, 12'h340, 1, 1, 32'hCAFEF00D, 0, 0, 0));
        sb.push_back(mk(K_DN, 3, 0, 5, 0, 32'h7, 32'h804, 1, 1));
        issue(csri(12'h340, 5'd1, 3'b001, 5'd5), 32'h800, 32'hCAFEF00D, 0, 0);
        instr = 32'h00000073; exc_req = 1'b1; exc_cause = 5'd9; start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0; exc_req = 1'b0;
        drain("busy_ignore");
        repeat (3) @(negedge clk);

        // reset in the WRITE cycle aborts the operation
        sb.push_back(mk(K_RD, 1, 12'h340, 0, 0, 0, 0, 0, 0));
        sb.push_back(mk(K_WR, 2, 12'h340, 1, 1, 32'h11112222, 0, 0, 0));
        issue(csri(12'h340, 5'd1, 3'b001, 5'd5), 32'h900, 32'h11112222, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("rst_mid");
        repeat (5) @(negedge clk);
        chk("rst_mid_leftover", 32'(sb.size()), 32'd0);
        sb.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
